// File: rtl/exception_sequencer.sv
// -----------------------------------------------------------------------------
// exception_sequencer
//
// Sequences entry into an exception handler. At an instruction boundary the
// highest-priority pending cause (DABT > FIQ > IRQ > UND > SWI) is captured.
// A fixed three-cycle entry sequence then runs:
//   ENTRY  : CPSR->SPSR copy, mode change, I/F masking, interrupt acknowledge
//   LINK   : banked LR write of return address + cause-specific offset
//   VECTOR : PC write of the cause's vector address
// All outputs are registered. Each output is computed for the state being
// entered, so it is valid for exactly the cycle spent in that state.
//
// Ports
//   clk             clock; all state changes on its rising edge
//   Rst_n           asynchronous active-low reset
//   INT_fiq/INT_irq level interrupt requests from the request block
//   CPSR_6/CPSR_7   F / I mask bits (1 = masked)
//   EXC_dabt/und/swi synchronous exception flags, valid with instr_boundary
//   instr_boundary  pipeline may be redirected this cycle
//   ret_addr        address of the instruction being interrupted
//   INTA_fiq/irq    one-cycle acknowledge pulses (ENTRY)
//   stall           holds the pipeline for ENTRY, LINK and VECTOR
//   spsr_we/mode_we SPSR copy and mode write strobes (ENTRY)
//   mode_out        new mode field, non-zero only with mode_we
//   set_I/set_F     set CPSR I / F bits (ENTRY)
//   lr_we/lr_data   banked LR write (LINK); lr_data zero otherwise
//   pc_we/pc_data   vector write to PC (VECTOR); pc_data zero otherwise
// -----------------------------------------------------------------------------
module exception_sequencer (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        INT_fiq,
  input  logic        INT_irq,
  input  logic        CPSR_6,
  input  logic        CPSR_7,
  input  logic        EXC_dabt,
  input  logic        EXC_und,
  input  logic        EXC_swi,
  input  logic        instr_boundary,
  input  logic [31:0] ret_addr,
  output logic        INTA_fiq,
  output logic        INTA_irq,
  output logic        stall,
  output logic        spsr_we,
  output logic        mode_we,
  output logic [4:0]  mode_out,
  output logic        set_I,
  output logic        set_F,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        pc_we,
  output logic [31:0] pc_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_LINK   = 2'd2,
    S_VECTOR = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_DABT = 3'd1,
    C_FIQ  = 3'd2,
    C_IRQ  = 3'd3,
    C_UND  = 3'd4,
    C_SWI  = 3'd5
  } cause_t;

  state_t      state;
  cause_t      cause;     // cause latched at capture, held for the sequence
  cause_t      sel_cause; // arbitration result for the current cycle
  logic [31:0] addr_q;    // ret_addr latched at capture

  // Mode field written on entry for each cause.
  function automatic logic [4:0] mode_of(input cause_t c);
    case (c)
      C_FIQ:   mode_of = 5'b10001;
      C_IRQ:   mode_of = 5'b10010;
      C_SWI:   mode_of = 5'b10011;
      C_DABT:  mode_of = 5'b10111;
      C_UND:   mode_of = 5'b11011;
      default: mode_of = 5'b00000;
    endcase
  endfunction

  // Return-address adjustment stored in the banked LR.
  function automatic logic [31:0] offset_of(input cause_t c);
    case (c)
      C_DABT:       offset_of = 32'd8;
      C_FIQ, C_IRQ: offset_of = 32'd4;
      default:      offset_of = 32'd0;
    endcase
  endfunction

  // Vector table address for each cause.
  function automatic logic [31:0] vector_of(input cause_t c);
    case (c)
      C_UND:   vector_of = 32'h0000_0004;
      C_SWI:   vector_of = 32'h0000_0008;
      C_DABT:  vector_of = 32'h0000_0010;
      C_IRQ:   vector_of = 32'h0000_0018;
      C_FIQ:   vector_of = 32'h0000_001C;
      default: vector_of = 32'h0000_0000;
    endcase
  endfunction

  // Fixed-priority arbitration. UND sits above SWI, so an undefined
  // instruction that also decodes as SWI is serviced as UND.
  always_comb begin
    // NOTE: default assignment first so every path drives sel_cause and no latch is inferred.
    sel_cause = C_NONE;
    if (EXC_dabt)                sel_cause = C_DABT;
    else if (INT_fiq && !CPSR_6) sel_cause = C_FIQ;
    else if (INT_irq && !CPSR_7) sel_cause = C_IRQ;
    else if (EXC_und)            sel_cause = C_UND;
    else if (EXC_swi)            sel_cause = C_SWI;
  end

  // NOTE: asynchronous reset clears state, latched cause/address and every
  // registered output, so outputs drop to 0 the moment Rst_n falls.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      cause    <= C_NONE;
      addr_q   <= '0;
      INTA_fiq <= 1'b0;
      INTA_irq <= 1'b0;
      stall    <= 1'b0;
      spsr_we  <= 1'b0;
      mode_we  <= 1'b0;
      mode_out <= '0;
      set_I    <= 1'b0;
      set_F    <= 1'b0;
      lr_we    <= 1'b0;
      lr_data  <= '0;
      pc_we    <= 1'b0;
      pc_data  <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden below for the state
      // being entered; every strobe and data field is therefore zero elsewhere.
      INTA_fiq <= 1'b0;
      INTA_irq <= 1'b0;
      stall    <= 1'b0;
      spsr_we  <= 1'b0;
      mode_we  <= 1'b0;
      mode_out <= '0;
      set_I    <= 1'b0;
      set_F    <= 1'b0;
      lr_we    <= 1'b0;
      lr_data  <= '0;
      pc_we    <= 1'b0;
      pc_data  <= '0;

      case (state)
        S_IDLE: begin
          if (instr_boundary && (sel_cause != C_NONE)) begin
            state    <= S_ENTRY;
            cause    <= sel_cause;
            addr_q   <= ret_addr;
            stall    <= 1'b1;
            spsr_we  <= 1'b1;
            mode_we  <= 1'b1;
            mode_out <= mode_of(sel_cause);
            set_I    <= 1'b1;
            set_F    <= (sel_cause == C_FIQ);
            INTA_fiq <= (sel_cause == C_FIQ);
            INTA_irq <= (sel_cause == C_IRQ);
          end
        end

        // Requests are ignored from here on; the latched cause drives the
        // rest of the sequence even if the request or its mask changes.
        S_ENTRY: begin
          state   <= S_LINK;
          stall   <= 1'b1;
          lr_we   <= 1'b1;
          lr_data <= addr_q + offset_of(cause);
        end

        S_LINK: begin
          state   <= S_VECTOR;
          stall   <= 1'b1;
          pc_we   <= 1'b1;
          pc_data <= vector_of(cause);
        end

        S_VECTOR: begin
          state <= S_IDLE;
          cause <= C_NONE;
        end

        default: begin
          state <= S_IDLE;
          cause <= C_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exception_sequencer
//
// Directed testbench for exception_sequencer. Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns after the edge that registers them.
// The single-bit strobes are packed into one vector for compact comparison:
//   obs = {INTA_fiq, INTA_irq, stall, spsr_we, mode_we, set_I, set_F, lr_we, pc_we}
// -----------------------------------------------------------------------------
module tb_exception_sequencer;

  logic        clk;
  logic        Rst_n;
  logic        INT_fiq, INT_irq, CPSR_6, CPSR_7;
  logic        EXC_dabt, EXC_und, EXC_swi, instr_boundary;
  logic [31:0] ret_addr;
  logic        INTA_fiq, INTA_irq, stall, spsr_we, mode_we, set_I, set_F;
  logic        lr_we, pc_we;
  logic [4:0]  mode_out;
  logic [31:0] lr_data, pc_data;
  logic [8:0]  obs;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [8:0] A_FIQ = 9'h100;
  localparam logic [8:0] A_IRQ = 9'h080;
  localparam logic [8:0] STL   = 9'h040;
  localparam logic [8:0] SPSR  = 9'h020;
  localparam logic [8:0] MODE  = 9'h010;
  localparam logic [8:0] SI    = 9'h008;
  localparam logic [8:0] SF    = 9'h004;
  localparam logic [8:0] LRW   = 9'h002;
  localparam logic [8:0] PCW   = 9'h001;
  localparam logic [8:0] ENT   = STL | SPSR | MODE | SI;

  exception_sequencer dut (
    .clk            (clk),
    .Rst_n          (Rst_n),
    .INT_fiq        (INT_fiq),
    .INT_irq        (INT_irq),
    .CPSR_6         (CPSR_6),
    .CPSR_7         (CPSR_7),
    .EXC_dabt       (EXC_dabt),
    .EXC_und        (EXC_und),
    .EXC_swi        (EXC_swi),
    .instr_boundary (instr_boundary),
    .ret_addr       (ret_addr),
    .INTA_fiq       (INTA_fiq),
    .INTA_irq       (INTA_irq),
    .stall          (stall),
    .spsr_we        (spsr_we),
    .mode_we        (mode_we),
    .mode_out       (mode_out),
    .set_I          (set_I),
    .set_F          (set_F),
    .lr_we          (lr_we),
    .lr_data        (lr_data),
    .pc_we          (pc_we),
    .pc_data        (pc_data)
  );

  assign obs = {INTA_fiq, INTA_irq, stall, spsr_we, mode_we, set_I, set_F, lr_we, pc_we};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    INT_fiq = 0; INT_irq = 0; CPSR_6 = 0; CPSR_7 = 0;
    EXC_dabt = 0; EXC_und = 0; EXC_swi = 0; instr_boundary = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ret_addr = 32'h0;
    Rst_n = 0;
    #12;
    n_cmp++;
    if (obs !== 9'h0) begin n_fail++; $display("FAIL reset strobes: got %b want %b", obs, 9'h0); end
    n_cmp++;
    if ({mode_out, lr_data, pc_data} !== 69'h0) begin
      n_fail++; $display("FAIL reset data: got mode=%b lr=%h pc=%h want 0", mode_out, lr_data, pc_data);
    end
    @(posedge clk); #1;
    Rst_n = 1;
    step();
    n_cmp++;
    if (obs !== 9'h0) begin n_fail++; $display("FAIL post_reset idle: got %b want %b", obs, 9'h0); end
  endtask

  task automatic test_irq_entry();
    INT_irq = 1; instr_boundary = 1; ret_addr = 32'h100;
    step();
    clear_inputs();
    n_cmp++;
    if (obs !== (ENT | A_IRQ)) begin n_fail++; $display("FAIL irq ENTRY strobes: got %b want %b", obs, ENT | A_IRQ); end
    n_cmp++;
    if (mode_out !== 5'b10010) begin n_fail++; $display("FAIL irq ENTRY mode: got %b want 10010", mode_out); end
    step();
    n_cmp++;
    if (obs !== (STL | LRW)) begin n_fail++; $display("FAIL irq LINK strobes: got %b want %b", obs, STL | LRW); end
    n_cmp++;
    if (lr_data !== 32'h104) begin n_fail++; $display("FAIL irq LINK lr_data: got %h want 00000104", lr_data); end
    n_cmp++;
    if (mode_out !== 5'b0) begin n_fail++; $display("FAIL irq LINK mode idle: got %b want 0", mode_out); end
    step();
    n_cmp++;
    if (obs !== (STL | PCW)) begin n_fail++; $display("FAIL irq VECTOR strobes: got %b want %b", obs, STL | PCW); end
    n_cmp++;
    if (pc_data !== 32'h18 || lr_data !== 32'h0) begin
      n_fail++; $display("FAIL irq VECTOR data: got pc=%h lr=%h want pc=00000018 lr=0", pc_data, lr_data);
    end
    step();
    n_cmp++;
    if (obs !== 9'h0 || pc_data !== 32'h0) begin
      n_fail++; $display("FAIL irq back IDLE: got %b pc=%h want 0", obs, pc_data);
    end
  endtask

  task automatic test_fiq_over_irq();
    INT_fiq = 1; INT_irq = 1; instr_boundary = 1; ret_addr = 32'h400;
    step();
    // Mask changes after capture must not abort the latched FIQ sequence.
    clear_inputs();
    CPSR_6 = 1;
    n_cmp++;
    if (obs !== (ENT | SF | A_FIQ)) begin n_fail++; $display("FAIL fiq ENTRY strobes: got %b want %b", obs, ENT | SF | A_FIQ); end
    n_cmp++;
    if (mode_out !== 5'b10001) begin n_fail++; $display("FAIL fiq ENTRY mode: got %b want 10001", mode_out); end
    step();
    n_cmp++;
    if (obs !== (STL | LRW) || lr_data !== 32'h404) begin
      n_fail++; $display("FAIL fiq LINK: got %b lr=%h want %b lr=00000404", obs, lr_data, STL | LRW);
    end
    step();
    n_cmp++;
    if (obs !== (STL | PCW) || pc_data !== 32'h1C) begin
      n_fail++; $display("FAIL fiq VECTOR: got %b pc=%h want %b pc=0000001c", obs, pc_data, STL | PCW);
    end
    CPSR_6 = 0;
    step();
  endtask

  task automatic test_masking();
    INT_irq = 1; CPSR_7 = 1; instr_boundary = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (obs !== 9'h0) begin n_fail++; $display("FAIL masked irq cycle %0d: got %b want 0", i, obs); end
    end
    clear_inputs();
    // A DABT without a boundary must not be captured either.
    EXC_dabt = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== 9'h0) begin n_fail++; $display("FAIL no boundary cycle %0d: got %b want 0", i, obs); end
    end
    clear_inputs();
  endtask

  task automatic test_dabt_over_fiq();
    EXC_dabt = 1; INT_fiq = 1; instr_boundary = 1; ret_addr = 32'h2000;
    step();
    clear_inputs();
    n_cmp++;
    if (obs !== ENT || mode_out !== 5'b10111) begin
      n_fail++; $display("FAIL dabt ENTRY: got %b mode=%b want %b mode=10111", obs, mode_out, ENT);
    end
    step();
    n_cmp++;
    if (obs !== (STL | LRW) || lr_data !== 32'h2008) begin
      n_fail++; $display("FAIL dabt LINK: got %b lr=%h want %b lr=00002008", obs, lr_data, STL | LRW);
    end
    step();
    n_cmp++;
    if (obs !== (STL | PCW) || pc_data !== 32'h10) begin
      n_fail++; $display("FAIL dabt VECTOR: got %b pc=%h want %b pc=00000010", obs, pc_data, STL | PCW);
    end
    step();
  endtask

  task automatic test_und_swi();
    EXC_und = 1; EXC_swi = 1; instr_boundary = 1; ret_addr = 32'h3000;
    step();
    clear_inputs();
    n_cmp++;
    if (obs !== ENT || mode_out !== 5'b11011) begin
      n_fail++; $display("FAIL und ENTRY: got %b mode=%b want %b mode=11011", obs, mode_out, ENT);
    end
    step();
    n_cmp++;
    if (lr_data !== 32'h3000) begin n_fail++; $display("FAIL und LINK lr_data: got %h want 00003000", lr_data); end
    step();
    n_cmp++;
    if (pc_data !== 32'h04) begin n_fail++; $display("FAIL und VECTOR pc_data: got %h want 00000004", pc_data); end
    step();
  endtask

  task automatic test_mid_reset();
    EXC_swi = 1; instr_boundary = 1; ret_addr = 32'h500;
    step();
    clear_inputs();
    step();
    n_cmp++;
    if (obs !== (STL | LRW)) begin n_fail++; $display("FAIL midrst in LINK: got %b want %b", obs, STL | LRW); end
    #2;
    Rst_n = 0;
    #1;
    n_cmp++;
    if (obs !== 9'h0 || lr_data !== 32'h0 || dut.state !== 2'd0) begin
      n_fail++; $display("FAIL midrst async clear: got %b lr=%h state=%0d want 0", obs, lr_data, dut.state);
    end
    step();
    step();
    Rst_n = 1;
    step();
    n_cmp++;
    if (obs !== 9'h0) begin n_fail++; $display("FAIL midrst no replay: got %b want 0", obs); end
    EXC_swi = 1; instr_boundary = 1; ret_addr = 32'h600;
    step();
    clear_inputs();
    n_cmp++;
    if (obs !== ENT || mode_out !== 5'b10011) begin
      n_fail++; $display("FAIL swi ENTRY: got %b mode=%b want %b mode=10011", obs, mode_out, ENT);
    end
    step();
    step();
    n_cmp++;
    if (obs !== (STL | PCW) || pc_data !== 32'h08) begin
      n_fail++; $display("FAIL swi VECTOR: got %b pc=%h want %b pc=00000008", obs, pc_data, STL | PCW);
    end
    step();
  endtask

  task automatic test_back_to_back();
    // IRQ and boundary stay high throughout: a second capture must follow
    // after exactly one IDLE cycle.
    INT_irq = 1; instr_boundary = 1; ret_addr = 32'hFFFF_FFFC;
    step();
    n_cmp++;
    if (obs !== (ENT | A_IRQ)) begin n_fail++; $display("FAIL b2b ENTRY1: got %b want %b", obs, ENT | A_IRQ); end
    step();
    n_cmp++;
    if (lr_data !== 32'h0000_0000 || lr_we !== 1'b1) begin
      n_fail++; $display("FAIL wrap lr_data: got %h we=%b want 00000000 we=1", lr_data, lr_we);
    end
    step();
    n_cmp++;
    if (obs !== (STL | PCW) || pc_data !== 32'h18) begin
      n_fail++; $display("FAIL b2b VECTOR1: got %b pc=%h want %b pc=00000018", obs, pc_data, STL | PCW);
    end
    ret_addr = 32'h800;
    step();
    n_cmp++;
    if (obs !== 9'h0) begin n_fail++; $display("FAIL b2b IDLE gap: got %b want 0", obs); end
    step();
    clear_inputs();
    n_cmp++;
    if (obs !== (ENT | A_IRQ) || mode_out !== 5'b10010) begin
      n_fail++; $display("FAIL b2b ENTRY2: got %b mode=%b want %b mode=10010", obs, mode_out, ENT | A_IRQ);
    end
    step();
    n_cmp++;
    if (lr_data !== 32'h804) begin n_fail++; $display("FAIL b2b LINK2 lr_data: got %h want 00000804", lr_data); end
    step();
    step();
    n_cmp++;
    if (obs !== 9'h0) begin n_fail++; $display("FAIL b2b final idle: got %b want 0", obs); end
  endtask

  initial begin
    test_reset();
    test_irq_entry();
    test_fiq_over_irq();
    test_masking();
    test_dabt_over_fiq();
    test_und_swi();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
